// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types, writeback-select codes and instruction field helpers for the hazard control unit.
// Imported by hazard_ctrl_unit and mem_wait_timer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        LD_REL   = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_t;

    localparam logic [1:0] WB_PC  = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    // Control bundle carried from DE into the MW stage register.
    typedef struct packed {
        logic       reg_wr;
        logic       rd_en;
        logic       wr_en;
        logic       csr_reg_rd;
        logic       csr_reg_wr;
        logic       is_mret;
        logic [1:0] wb_sel;
    } mw_ctrl_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_mem_wait_timer.sv
// Wait counter for multi-cycle data-memory accesses: counts while inc is high,
// flags the last allowed cycle (expired) and latches a sticky timeout.
module mem_wait_timer
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (clear) begin
                cnt_reg <= '0;
            end else if (inc) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // Sticky until reset: a release by expiry is recorded once and kept.
            if (inc && expired) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign expired = (cnt_reg == LAST_CNT);
    assign timeout = timeout_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 3-stage pipeline: MW control register, ALU forwarding,
// load-use stall, data-memory wait and branch/trap flush. Optional PERF_CNT_EN adds counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction2,
    input  logic [31:0] instruction3,
    input  logic        br_taken3,
    input  logic        epc_taken,
    input  logic        mem_ready,
    input  logic        reg_wr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        CSR_reg_rd,
    input  logic        CSR_reg_wr,
    input  logic        is_mret,
    input  logic [1:0]  wb_sel,
    output logic        reg_wrMW,
    output logic        rd_enMW,
    output logic        wr_enMW,
    output logic        CSR_reg_rdMW,
    output logic        CSR_reg_wrMW,
    output logic        is_mretMW,
    output logic [1:0]  wb_selMW,
    output logic        stall,
    output logic        stallMW,
    output logic        flush,
    output logic        forward_A,
    output logic        forward_B,
    output logic        mem_timeout
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    hz_state_t state_reg, state_next;
    mw_ctrl_t  de_ctrl, mw_reg, mw_next;

    logic [4:0] rd3;
    logic [4:0] rs_de [2];
    logic [1:0] alu_hit;
    logic [1:0] mem_hit;
    logic       ld_hz;
    logic       mem_req;
    logic       redirect;
    logic       stall_int;
    logic       timer_clear;
    logic       timer_inc;
    logic       timer_expired;
    logic       unused_bits;

    assign rd3      = rd_of(instruction3);
    assign rs_de[0] = rs1_of(instruction2);
    assign rs_de[1] = rs2_of(instruction2);

    // Only the register fields are decoded; opcode/funct bits are not needed here.
    assign unused_bits = ^{instruction2[31:25], instruction2[14:0],
                           instruction3[31:12], instruction3[6:0]};

    // Per-operand producer match: ALU results forward, loads force a stall.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic rd_match;
            assign rd_match    = mw_reg.reg_wr && (rd3 != 5'd0) && (rd3 == rs_de[gi]);
            assign alu_hit[gi] = rd_match && (mw_reg.wb_sel == WB_ALU);
            assign mem_hit[gi] = rd_match && (mw_reg.wb_sel == WB_MEM);
        end
    endgenerate

    assign forward_A = ~alu_hit[0];
    assign forward_B = ~alu_hit[1];
    assign ld_hz     = |mem_hit;
    assign mem_req   = mw_reg.rd_en | mw_reg.wr_en;
    assign redirect  = br_taken3 | epc_taken;

    always_comb begin
        state_next = state_reg;
        stall_int  = 1'b0;
        flush      = redirect;
        unique case (state_reg)
            RUN, LD_REL: begin
                if (redirect) begin
                    state_next = RUN;
                end else if (mem_req && !mem_ready) begin
                    state_next = MEM_WAIT;
                end else if ((state_reg == RUN) && ld_hz) begin
                    state_next = LD_STALL;
                end else begin
                    state_next = RUN;
                end
            end
            LD_STALL: begin
                stall_int  = ~redirect;
                state_next = redirect ? RUN : LD_REL;
            end
            MEM_WAIT: begin
                stall_int = ~redirect;
                if (redirect || mem_ready || timer_expired) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign stall   = stall_int;
    assign stallMW = stall_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    assign de_ctrl = {reg_wr, rd_en, wr_en, CSR_reg_rd, CSR_reg_wr, is_mret, wb_sel};

    // A flush inserts a bubble; otherwise the register follows DE unless frozen.
    always_comb begin
        mw_next = mw_reg;
        if (flush) begin
            mw_next = '0;
        end else if (!stall_int) begin
            mw_next = de_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mw_reg <= '0;
        end else begin
            mw_reg <= mw_next;
        end
    end

    assign reg_wrMW     = mw_reg.reg_wr;
    assign rd_enMW      = mw_reg.rd_en;
    assign wr_enMW      = mw_reg.wr_en;
    assign CSR_reg_rdMW = mw_reg.csr_reg_rd;
    assign CSR_reg_wrMW = mw_reg.csr_reg_wr;
    assign is_mretMW    = mw_reg.is_mret;
    assign wb_selMW     = mw_reg.wb_sel;

    assign timer_inc   = (state_reg == MEM_WAIT) && !redirect && !mem_ready;
    assign timer_clear = (state_reg != MEM_WAIT) || redirect || mem_ready || timer_expired;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired),
        .timeout (mem_timeout)
    );

`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall_int) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (flush) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule
